// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: WIDTH-bit adder that evaluates CHUNK bits per clock, LSB chunk first,
// with a registered carry between chunks and valid/ready handshakes on both sides.
module serial_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LASTIDX = IDXW'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : gBadParams
      $error("serial_chunk_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d) with 1 <= CHUNK <= WIDTH",
             WIDTH, CHUNK);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aWork_q, aWork_d;
  logic [WIDTH-1:0] bWork_q, bWork_d;
  logic [WIDTH-1:0] sumWork_q, sumWork_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             chunkCarry_q, chunkCarry_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  int               bitBase;
  logic [CHUNK-1:0] chunkSum;
  logic             chunkCout;

  // Only one CHUNK-bit adder exists; the full-width ripple is spread over NCHUNK clocks.
  assign bitBase = int'(idx_q) * CHUNK;
  assign {chunkCout, chunkSum} = {1'b0, aWork_q[bitBase +: CHUNK]}
                               + {1'b0, bWork_q[bitBase +: CHUNK]}
                               + {{CHUNK{1'b0}}, chunkCarry_q};

  always_comb begin
    state_d      = state_q;
    aWork_d      = aWork_q;
    bWork_d      = bWork_q;
    sumWork_d    = sumWork_q;
    sum_d        = sum_q;
    chunkCarry_d = chunkCarry_q;
    carry_d      = carry_q;
    overflow_d   = overflow_q;
    idx_d        = idx_q;
    in_ready     = (state_q == IDLE) && !rst;
    out_valid    = (state_q == DONE) && !rst;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          aWork_d      = a;
          bWork_d      = b;
          chunkCarry_d = cin;
          idx_d        = '0;
          state_d      = ADD;
        end
      end
      ADD: begin
        sumWork_d[bitBase +: CHUNK] = chunkSum;
        chunkCarry_d                = chunkCout;
        idx_d                       = idx_q + 1'b1;
        if (idx_q == LASTIDX) begin
          // Result registers are loaded only here, so they hold steady in IDLE and ADD.
          idx_d      = '0;
          state_d    = DONE;
          sum_d      = sumWork_d;
          carry_d    = chunkCout;
          overflow_d = (aWork_q[WIDTH-1] == bWork_q[WIDTH-1]) &&
                       (sumWork_d[WIDTH-1] != aWork_q[WIDTH-1]);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      aWork_q      <= '0;
      bWork_q      <= '0;
      sumWork_q    <= '0;
      sum_q        <= '0;
      chunkCarry_q <= 1'b0;
      carry_q      <= 1'b0;
      overflow_q   <= 1'b0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      aWork_q      <= aWork_d;
      bWork_q      <= bWork_d;
      sumWork_q    <= sumWork_d;
      sum_q        <= sum_d;
      chunkCarry_q <= chunkCarry_d;
      carry_q      <= carry_d;
      overflow_q   <= overflow_d;
      idx_q        <= idx_d;
    end
  end

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule
